daq_result_fifo: RTL and testbench
==================================

Name: daq_result_fifo

Overview:
- Downstream stage of the DAQ counter core: captures per-channel count results when the core raises O_READY_0/O_READY_1, tags them, and buffers them in one shared FIFO for processor readout.
- Its output side is read by the AXI-lite register slice, or by a later DMA, through a first-word-fall-through pop interface.
- Prevents result loss when software polls slower than the Z-pulse rate, and reports any results it does lose.

Parameters:
CNT_W, 32, width of each channel count result
DEPTH, 16, FIFO entries; power of two, minimum 2
IRQ_THRESH, 8, O_IRQ asserts when O_LEVEL >= IRQ_THRESH; range 1..DEPTH

Ports:
s00_axi_aclk  in  1  sole clock
s00_axi_aresetn  in  1  asynchronous active-low reset
I_CNT_0  in  CNT_W  channel-0 count result
I_READY_0  in  1  channel-0 result-ready level from the counter core
I_OVERFLOW_0  in  1  channel-0 overflow flag
I_CNT_1  in  CNT_W  channel-1 count result
I_READY_1  in  1  channel-1 result-ready level
I_OVERFLOW_1  in  1  channel-1 overflow flag
I_CLR  in  1  synchronous flush
I_POP  in  1  consume head entry
O_DATA  out  CNT_W+2  head entry, {ch, ovf, count}
O_VALID  out  1  head entry valid (equals !O_EMPTY)
O_EMPTY  out  1  FIFO empty
O_FULL  out  1  FIFO full
O_LEVEL  out  clog2(DEPTH)+1  occupancy
O_DROP_CNT  out  16  results lost, saturating
O_IRQ  out  1  level interrupt

Behaviour:
Reset values:
- O_DATA=0, O_VALID=0, O_EMPTY=1, O_FULL=0, O_LEVEL=0, O_DROP_CNT=0, O_IRQ=0.
- Pointers, pending registers, grant history and READY-history registers all reset to 0.

Capture:
- A rising edge of I_READY_x is detected when READY is 1 at edge N and was 0 at edge N-1.
- At edge N, I_CNT_x and I_OVERFLOW_x are latched into pending_x.
- Because history resets to 0, a READY held at 1 through reset release is captured once.

Write arbitration:
- On each edge, one pending entry is written to the FIFO if the FIFO is not full.
- If only one entry is pending, it is written.
- If both are pending, the channel not granted last time is written; the history resets to favour ch0.
- Worst-case wait for a pending entry is one extra cycle.

Latency and entry format:
- A single channel written at edge N+1 gives O_VALID=1 in the cycle after edge N+1.
- ch = 0 or 1; ovf = the latched overflow flag.

Full FIFO:
- A pending entry that finds the FIFO full at its write attempt is discarded.
- O_DROP_CNT increments by one per discarded entry and saturates at 0xFFFF.
- A new READY edge on a channel whose pending entry is still occupied overwrites that entry; the overwritten entry counts as a drop.

Pop:
- I_POP with O_VALID=1 at an edge advances the head.
- I_POP with O_EMPTY=1 is ignored and has no error side effect.

Simultaneous push and pop:
- Both happen. O_LEVEL is unchanged.
- When full, the pop frees a slot and the push is accepted in the same edge; no drop.

Status outputs:
- O_LEVEL, O_FULL, O_EMPTY and O_IRQ are registered and consistent with pointer state after every edge.
- Pointers wrap modulo DEPTH; an extra pointer bit distinguishes full from empty.

Flush:
- I_CLR at an edge zeroes pointers, O_LEVEL, pending registers and O_DROP_CNT.
- It does not clear READY history; a capture detected on the same edge is discarded.
- I_CLR has priority over push and pop.

Asynchronous reset:
- Reset asserted mid-operation returns all state to reset values immediately.
- Buffered contents are lost.

Optional Feature:
- Macro: DAQ_RESULT_TIMESTAMP_EN.
- When defined:
  - A free-running 32-bit cycle counter (reset 0, wraps) is added.
  - Its value at the capture edge is stored with each entry.
  - An extra output port O_TSTAMP [31:0] presents the head entry's timestamp, valid with O_VALID.
  - FIFO width grows by 32.
- When undefined: no counter, no O_TSTAMP port, FIFO width is CNT_W+2.

Test Plan:
- Single capture: I_CNT_0=3, READY_0 rising at edge 10 -> O_VALID=1 after edge 11; O_DATA={0,0,3}; O_LEVEL=1; I_POP -> O_EMPTY=1.
- Simultaneous capture: READY_0 and READY_1 rise together, CNT=5/7 -> entries in order ch0 (5) then ch1 (7); next simultaneous event -> order ch1, ch0.
- Overflow and full: 17 results with no pops, DEPTH=16 -> O_FULL=1, O_LEVEL=16, O_DROP_CNT=1; pop plus capture in the same cycle -> O_DROP_CNT stays 1.
- Threshold IRQ: push 7 -> O_IRQ=0; 8th -> O_IRQ=1; pop one -> O_IRQ=0.
- Flush and reset: I_CLR with 4 entries -> O_LEVEL=0, O_DROP_CNT=0; aresetn low mid-stream -> all outputs at reset values within the same cycle.
- Timestamp build: DAQ_RESULT_TIMESTAMP_EN defined, captures at cycles 100 and 250 -> O_TSTAMP delta = 150.

Source files
------------

// File: rtl/daq_result_fifo.sv
// Captures tagged per-channel count results on READY rising edges into one shared FWFT FIFO.
// Optional macro DAQ_RESULT_TIMESTAMP_EN stores a 32-bit capture timestamp per entry (O_TSTAMP).
module daq_result_fifo #(
    parameter int CNT_W      = 32,
    parameter int DEPTH      = 16,
    parameter int IRQ_THRESH = 8
) (
    input  logic                         s00_axi_aclk,
    input  logic                         s00_axi_aresetn,
    input  logic [CNT_W-1:0]             I_CNT_0,
    input  logic                         I_READY_0,
    input  logic                         I_OVERFLOW_0,
    input  logic [CNT_W-1:0]             I_CNT_1,
    input  logic                         I_READY_1,
    input  logic                         I_OVERFLOW_1,
    input  logic                         I_CLR,
    input  logic                         I_POP,
    output logic [CNT_W+1:0]             O_DATA,
    output logic                         O_VALID,
    output logic                         O_EMPTY,
    output logic                         O_FULL,
    output logic [$clog2(DEPTH):0]       O_LEVEL,
    output logic [15:0]                  O_DROP_CNT,
`ifdef DAQ_RESULT_TIMESTAMP_EN
    output logic [31:0]                  O_TSTAMP,
`endif
    output logic                         O_IRQ
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = CNT_W + 2;
`ifdef DAQ_RESULT_TIMESTAMP_EN
    localparam int EW = DW + 32;
`else
    localparam int EW = DW;
`endif

    logic             rdy_q0, rdy_q1;
    logic             pv0, pv1, po0, po1, prio1;
    logic [CNT_W-1:0] pc0, pc1;
    logic [AW:0]      wptr, rptr, wptr_n, rptr_n;
    logic [LW-1:0]    level_q, level_n;
    logic             empty_q, full_q, irq_q;
    logic [15:0]      drop_q;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    wdata, head;

    logic rise0, rise1, gnt0, gnt1, wr_try, wr_ok, do_pop;
    logic drop_wr, ovr0, ovr1;
    logic [1:0]  n_drop;
    logic [16:0] drop_sum;

`ifdef DAQ_RESULT_TIMESTAMP_EN
    logic [31:0] ts_q, pt0, pt1;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            ts_q <= '0;
            pt0  <= '0;
            pt1  <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (rise0) pt0 <= ts_q;
            if (rise1) pt1 <= ts_q;
        end
    end

    assign wdata    = gnt1 ? {pt1, 1'b1, po1, pc1} : {pt0, 1'b0, po0, pc0};
    assign O_TSTAMP = empty_q ? '0 : head[EW-1:DW];
`else
    assign wdata = gnt1 ? {1'b1, po1, pc1} : {1'b0, po0, pc0};
`endif

    assign rise0 = I_READY_0 & ~rdy_q0;
    assign rise1 = I_READY_1 & ~rdy_q1;

    // Round-robin applies only under contention; prio1 remembers who waited.
    assign gnt0   = pv0 & (~pv1 | ~prio1);
    assign gnt1   = pv1 & (~pv0 | prio1);
    assign wr_try = gnt0 | gnt1;
    assign do_pop = I_POP & ~empty_q;
    assign wr_ok  = wr_try & (~full_q | do_pop);

    assign drop_wr  = wr_try & ~wr_ok;
    assign ovr0     = rise0 & pv0 & ~gnt0;
    assign ovr1     = rise1 & pv1 & ~gnt1;
    assign n_drop   = {1'b0, drop_wr} + {1'b0, ovr0} + {1'b0, ovr1};
    assign drop_sum = {1'b0, drop_q} + {15'd0, n_drop};

    assign wptr_n  = wptr + {{AW{1'b0}}, wr_ok};
    assign rptr_n  = rptr + {{AW{1'b0}}, do_pop};
    assign level_n = wptr_n - rptr_n;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rdy_q0  <= 1'b0;
            rdy_q1  <= 1'b0;
            pv0     <= 1'b0;
            pv1     <= 1'b0;
            po0     <= 1'b0;
            po1     <= 1'b0;
            pc0     <= '0;
            pc1     <= '0;
            prio1   <= 1'b0;
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            irq_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            rdy_q0 <= I_READY_0;
            rdy_q1 <= I_READY_1;
            if (I_CLR) begin
                pv0     <= 1'b0;
                pv1     <= 1'b0;
                po0     <= 1'b0;
                po1     <= 1'b0;
                pc0     <= '0;
                pc1     <= '0;
                wptr    <= '0;
                rptr    <= '0;
                level_q <= '0;
                empty_q <= 1'b1;
                full_q  <= 1'b0;
                irq_q   <= 1'b0;
                drop_q  <= '0;
            end else begin
                wptr    <= wptr_n;
                rptr    <= rptr_n;
                level_q <= level_n;
                empty_q <= (level_n == '0);
                full_q  <= (level_n == LW'(DEPTH));
                irq_q   <= (level_n >= LW'(IRQ_THRESH));
                drop_q  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                if (pv0 && pv1) prio1 <= gnt0;
                pv0 <= rise0 | (pv0 & ~gnt0);
                pv1 <= rise1 | (pv1 & ~gnt1);
                if (rise0) begin
                    pc0 <= I_CNT_0;
                    po0 <= I_OVERFLOW_0;
                end
                if (rise1) begin
                    pc1 <= I_CNT_1;
                    po1 <= I_OVERFLOW_1;
                end
            end
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (wr_ok && !I_CLR) mem[wptr[AW-1:0]] <= wdata;
    end

    assign head       = mem[rptr[AW-1:0]];
    assign O_DATA     = empty_q ? '0 : head[DW-1:0];
    assign O_VALID    = ~empty_q;
    assign O_EMPTY    = empty_q;
    assign O_FULL     = full_q;
    assign O_LEVEL    = level_q;
    assign O_DROP_CNT = drop_q;
    assign O_IRQ      = irq_q;

endmodule

// File: tb/tb_daq_result_fifo.sv
// Directed scoreboard bench for daq_result_fifo (default DEPTH=16, IRQ_THRESH=8).
// Timestamp delta check is included when DAQ_RESULT_TIMESTAMP_EN is defined.
module tb_daq_result_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cnt0 = '0, cnt1 = '0;
    logic        rdy0 = 1'b0, rdy1 = 1'b0, ovf0 = 1'b0, ovf1 = 1'b0;
    logic        clr = 1'b0, pop = 1'b0;
    logic [33:0] o_data;
    logic        o_valid, o_empty, o_full, o_irq;
    logic [4:0]  o_level;
    logic [15:0] o_drop;
`ifdef DAQ_RESULT_TIMESTAMP_EN
    logic [31:0] o_ts;
`endif

    int passed = 0;
    int total  = 0;
    logic [33:0] sb[$];

    always #5 clk = ~clk;

    daq_result_fifo dut (
        .s00_axi_aclk   (clk),
        .s00_axi_aresetn(rst_n),
        .I_CNT_0        (cnt0),
        .I_READY_0      (rdy0),
        .I_OVERFLOW_0   (ovf0),
        .I_CNT_1        (cnt1),
        .I_READY_1      (rdy1),
        .I_OVERFLOW_1   (ovf1),
        .I_CLR          (clr),
        .I_POP          (pop),
        .O_DATA         (o_data),
        .O_VALID        (o_valid),
        .O_EMPTY        (o_empty),
        .O_FULL         (o_full),
        .O_LEVEL        (o_level),
        .O_DROP_CNT     (o_drop),
`ifdef DAQ_RESULT_TIMESTAMP_EN
        .O_TSTAMP       (o_ts),
`endif
        .O_IRQ          (o_irq)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_data"}, 64'(o_data), 64'd0);
        chk({tag, "_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_empty"}, 64'(o_empty), 64'd1);
        chk({tag, "_full"}, 64'(o_full), 64'd0);
        chk({tag, "_level"}, 64'(o_level), 64'd0);
        chk({tag, "_drop"}, 64'(o_drop), 64'd0);
        chk({tag, "_irq"}, 64'(o_irq), 64'd0);
    endtask

    // Raise READY for one edge (capture edge), then drop it.
    task automatic capture(input logic r0, input logic r1,
                           input logic [31:0] c0, input logic [31:0] c1,
                           input logic v0, input logic v1);
        rdy0 = r0; rdy1 = r1;
        cnt0 = c0; cnt1 = c1;
        ovf0 = v0; ovf1 = v1;
        tick();
        rdy0 = 1'b0; rdy1 = 1'b0;
        ovf0 = 1'b0; ovf1 = 1'b0;
    endtask

    task automatic pop_chk(input string tag);
        logic [33:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 34'h3_FFFF_FFFF;
        chk({tag, "_valid"}, 64'(o_valid), 64'd1);
        chk({tag, "_data"}, 64'(o_data), 64'(e));
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        chk_reset("reset");
        rst_n = 1'b1;
        tick();

        // single capture and FWFT latency
        sb.push_back({1'b0, 1'b0, 32'd3});
        capture(1'b1, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0);
        chk("single_lat_valid", 64'(o_valid), 64'd0);
        tick();
        chk("single_level", 64'(o_level), 64'd1);
        pop_chk("single");
        chk("single_empty", 64'(o_empty), 64'd1);

        // pop on empty is ignored
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("empty_pop_level", 64'(o_level), 64'd0);
        chk("empty_pop_drop", 64'(o_drop), 64'd0);

        // simultaneous captures alternate priority
        sb.push_back({1'b0, 1'b0, 32'd5});
        sb.push_back({1'b1, 1'b0, 32'd7});
        capture(1'b1, 1'b1, 32'd5, 32'd7, 1'b0, 1'b0);
        repeat (2) tick();
        chk("simul_level", 64'(o_level), 64'd2);
        pop_chk("simul_a0");
        pop_chk("simul_a1");
        sb.push_back({1'b1, 1'b1, 32'd9});
        sb.push_back({1'b0, 1'b0, 32'd8});
        capture(1'b1, 1'b1, 32'd8, 32'd9, 1'b0, 1'b1);
        repeat (2) tick();
        pop_chk("simul_b0");
        pop_chk("simul_b1");
        chk("simul_empty", 64'(o_empty), 64'd1);

        // fill, threshold IRQ, full and drop
        for (int i = 0; i < 16; i++) begin
            sb.push_back({1'(i), 1'(i == 3), 32'(100 + i)});
            capture(~1'(i), 1'(i), 32'(100 + i), 32'(100 + i),
                    1'(i == 3), 1'(i == 3));
            tick();
            if (i == 6) begin
                chk("irq_at7", 64'(o_irq), 64'd0);
                chk("level_at7", 64'(o_level), 64'd7);
            end
            if (i == 7) chk("irq_at8", 64'(o_irq), 64'd1);
        end
        chk("full_flag", 64'(o_full), 64'd1);
        chk("full_level", 64'(o_level), 64'd16);
        chk("full_nodrop", 64'(o_drop), 64'd0);
        capture(1'b1, 1'b0, 32'd999, 32'd0, 1'b0, 1'b0);
        tick();
        chk("drop_one", 64'(o_drop), 64'd1);
        chk("drop_level", 64'(o_level), 64'd16);

        // pop and push on the same edge while full
        capture(1'b1, 1'b0, 32'd555, 32'd0, 1'b0, 1'b0);
        chk("pp_data", 64'(o_data), 64'(sb[0]));
        void'(sb.pop_front());
        sb.push_back({1'b0, 1'b0, 32'd555});
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("pp_drop", 64'(o_drop), 64'd1);
        chk("pp_level", 64'(o_level), 64'd16);
        chk("pp_full", 64'(o_full), 64'd1);

        for (int i = 0; i < 8; i++) pop_chk("drain_a");
        chk("drain_irq8", 64'(o_irq), 64'd1);
        pop_chk("drain_b");
        chk("drain_irq7", 64'(o_irq), 64'd0);
        chk("drain_level7", 64'(o_level), 64'd7);
        for (int i = 0; i < 7; i++) pop_chk("drain_c");
        chk("drain_empty", 64'(o_empty), 64'd1);

        // flush clears level and drop count
        for (int i = 0; i < 4; i++) begin
            capture(1'b0, 1'b1, 32'(i), 32'(i), 1'b0, 1'b0);
            tick();
        end
        chk("pre_clr_level", 64'(o_level), 64'd4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_level", 64'(o_level), 64'd0);
        chk("clr_drop", 64'(o_drop), 64'd0);
        chk("clr_valid", 64'(o_valid), 64'd0);
        clr = 1'b1;
        capture(1'b0, 1'b1, 32'd0, 32'd77, 1'b0, 1'b0);
        clr = 1'b0;
        repeat (2) tick();
        chk("clr_capture_discard", 64'(o_empty), 64'd1);

        // asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            capture(1'b1, 1'b0, 32'(40 + i), 32'd0, 1'b0, 1'b0);
            tick();
        end
        chk("pre_rst_level", 64'(o_level), 64'd3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        sb.push_back({1'b1, 1'b0, 32'hDEAD_BEEF});
        capture(1'b0, 1'b1, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        tick();
        pop_chk("post_rst");

`ifdef DAQ_RESULT_TIMESTAMP_EN
        begin
            logic [31:0] t0;
            sb.push_back({1'b0, 1'b0, 32'd1});
            sb.push_back({1'b0, 1'b0, 32'd2});
            capture(1'b1, 1'b0, 32'd1, 32'd0, 1'b0, 1'b0);
            repeat (149) tick();
            capture(1'b1, 1'b0, 32'd2, 32'd0, 1'b0, 1'b0);
            tick();
            t0 = o_ts;
            pop_chk("ts_a");
            chk("ts_delta", 64'(o_ts - t0), 64'd150);
            pop_chk("ts_b");
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
